serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_baud_div.sv | 46 ++++
 rtl/serial_tx.sv | 124 ++++++++++++
 tb/tb_serial_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg -- definitions shared by the serial transmitter files.
//   tx_state_e       : frame FSM states (IDLE, START, DATA, STOP)
//   DEF_DATA_W       : default payload width in bits
//   DEF_CLKS_PER_BIT : default number of clk cycles per serial bit
//   cnt_w()          : width of a counter covering 0..n-1 (never less than 1)
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_baud_div.sv
// serial_baud_div -- bit-period divider for the serial transmitter.
// Counts clk cycles while enabled and flags the last cycle of each bit.
//   clk   : clock
//   reset : synchronous active-high reset, counter returns to 0
//   clear : restart the bit period (frame start); counter returns to 0
//   en    : count while a frame is in flight
//   tick  : high during the final cycle of the current bit period
module serial_baud_div
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W    = cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap at the terminal count so each bit lasts exactly CLKS_PER_BIT cycles.
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx -- asynchronous-style serial transmitter (start 0, data LSB first,
// stop 1), each bit held CLKS_PER_BIT clk cycles.
//   clk      : clock
//   reset    : synchronous active-high reset; aborts any frame in flight
//   tx_valid : tx_data holds a word to send
//   tx_data  : payload word, latched on the accepting edge
//   tx_ready : block can accept a word this cycle (IDLE only)
//   tx_out   : registered serial line, idle high
//   busy     : frame in progress (complement of tx_ready)
//   tx_done  : one-cycle pulse in the first IDLE cycle after a frame
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int              IDX_W    = cnt_w(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;

    logic              accept;
    logic              bit_tick;
    logic [DATA_W-1:0] shift_nxt;

    assign accept    = tx_valid && (state_q == IDLE);
    assign shift_nxt = shift_q >> 1;

    serial_baud_div #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_div (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state_q != IDLE),
        .tick  (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_out_d  = tx_out_q;
        tx_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    tx_out_d  = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_out_d  = 1'b1;
                    end else begin
                        // Present the next bit on the line as the register shifts.
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_nxt;
                        tx_out_d  = shift_nxt[0];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d   = IDLE;
                    tx_out_d  = 1'b1;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = !tx_ready;
    assign tx_out   = tx_out_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- directed bench for serial_tx.
// dut_a uses DATA_W=8, CLKS_PER_BIT=4; dut_b uses DATA_W=8, CLKS_PER_BIT=1.
// Expected line sequences are hand-computed 10-bit vectors, element 0 first.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, a_ready, a_out, a_busy, a_done;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_out, b_busy, b_done;
    logic [7:0] b_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (a_valid),
        .tx_data  (a_data),
        .tx_ready (a_ready),
        .tx_out   (a_out),
        .busy     (a_busy),
        .tx_done  (a_done)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (b_valid),
        .tx_data  (b_data),
        .tx_ready (b_ready),
        .tx_out   (b_out),
        .busy     (b_busy),
        .tx_done  (b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after the accepting edge. Walks the whole
    // frame, then checks the tx_done cycle. With junk set, dut_a gets a
    // 0x3C request mid-frame that must be ignored.
    task automatic expect_frame(input string name, input bit use_b, input int cpb,
                                input logic [9:0] seq, input bit junk);
        for (int k = 1; k <= 10 * cpb; k++) begin
            int idx;
            idx = (k - 1) / cpb;
            if (junk && k == 5) begin
                a_valid = 1'b1;
                a_data  = 8'h3C;
            end
            if (junk && k == 31) begin
                a_valid = 1'b0;
            end
            check($sformatf("%s_out_c%0d", name, k), use_b ? b_out : a_out, seq[idx]);
            check($sformatf("%s_busy_c%0d", name, k), use_b ? b_busy : a_busy, 1);
            check($sformatf("%s_done_c%0d", name, k), use_b ? b_done : a_done, 0);
            tick();
        end
        check($sformatf("%s_done_end", name), use_b ? b_done : a_done, 1);
        check($sformatf("%s_out_end", name), use_b ? b_out : a_out, 1);
        check($sformatf("%s_ready_end", name), use_b ? b_ready : a_ready, 1);
        $display("frame %s: line 0x%03h checked over %0d cycles", name, seq, 10 * cpb + 1);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 8'h00;

        // Reset held for two edges.
        tick();
        tick();
        reset = 1'b0;
        check("rst_out", a_out, 1);
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_b_ready", b_ready, 1);
        $display("reset: idle state checked");

        // Plain 0xA5 frame.
        a_valid = 1'b1;
        a_data  = 8'hA5;
        tick();
        a_valid = 1'b0;
        expect_frame("a5", 1'b0, 4, 10'b1101001010, 1'b0);
        tick();
        check("a5_done_after", a_done, 0);

        // 0xA5 with a 0x3C request arriving mid-frame.
        a_valid = 1'b1;
        a_data  = 8'hA5;
        tick();
        a_valid = 1'b0;
        expect_frame("a5_junk", 1'b0, 4, 10'b1101001010, 1'b1);
        tick();
        check("junk_done_after", a_done, 0);
        check("junk_not_sent", a_out, 1);

        // Back-to-back: valid held through 0x00 then 0xFF.
        a_valid = 1'b1;
        a_data  = 8'h00;
        tick();
        a_data  = 8'hFF;
        expect_frame("b2b_00", 1'b0, 4, 10'b1000000000, 1'b0);
        tick();
        a_valid = 1'b0;
        expect_frame("b2b_ff", 1'b0, 4, 10'b1111111110, 1'b0);
        tick();
        check("b2b_done_after", a_done, 0);

        // Reset during data bit 3 (cycles 17..20 after accept).
        a_valid = 1'b1;
        a_data  = 8'hA5;
        tick();
        a_valid = 1'b0;
        repeat (17) tick();
        check("mid_bit3_out", a_out, 0);
        check("mid_bit3_busy", a_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out", a_out, 1);
        check("mid_rst_ready", a_ready, 1);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_done", a_done, 0);
        for (int k = 0; k < 45; k++) begin
            tick();
            check($sformatf("mid_rst_nodone_c%0d", k), a_done, 0);
            check($sformatf("mid_rst_idle_c%0d", k), a_out, 1);
        end
        $display("abort: reset mid-frame checked");

        // CLKS_PER_BIT=1 instance sending 0x3C.
        b_valid = 1'b1;
        b_data  = 8'h3C;
        tick();
        b_valid = 1'b0;
        expect_frame("cpb1_3c", 1'b1, 1, 10'b1001111000, 1'b0);
        tick();
        check("cpb1_done_after", b_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
